// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 / 8E1 / 8O1 UART transmitter with a valid/ready byte intake.
//
// Handshake: a byte moves from requester to controller on a rising clock edge
// where tx_valid=1 and tx_ready=1. tx_ready is high only while IDLE. tx_data
// is sampled only at that edge, and tx_valid is ignored at every other time.
// done pulses for the single IDLE cycle that follows a frame's stop bit. A byte
// offered in that cycle is accepted at its closing edge.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] TIMER_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        parity_q, parity_d;
    logic        done_q, done_d;
    logic        bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (timer_q == TIMER_MAX);

    // State register and datapath flops; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            done_q    <= done_d;
        end
    end

    // Next-state, bit timing and serial output decode.
    always_comb begin
        state_d   = state_q;
        timer_d   = bit_end ? 16'd0 : timer_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        tx        = 1'b1;

        case (state_q)
            IDLE: begin
                tx      = 1'b1;
                timer_d = '0;
                if (tx_valid) begin
                    // Parity is fixed from the byte as latched, so later
                    // tx_data changes cannot disturb it.
                    shreg_d   = tx_data;
                    parity_d  = (^tx_data) ^ PARITY_ODD;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shreg_q[0];
                if (bit_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tx = parity_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                tx = 1'b1;
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                tx      = 1'b1;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs.
    assign tx_ready  = (state_q == IDLE);
    assign busy      = ~tx_ready;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0, 1 inserts a parity bit between data and stop.
REQ-003 Parameter PARITY_ODD, default 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-007 tx_valid  input  1  requester has a byte on tx_data.
REQ-008 tx_ready  output  1  controller can accept a byte this cycle.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 tx_ready SHALL be 1 exactly when state is IDLE; busy SHALL be its complement.
REQ-014 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into an internal 8-bit shift register at that edge, and the state SHALL go to START.
REQ-015 tx_data changes and tx_valid while busy=1 SHALL have no effect on the frame in progress.
REQ-016 An internal bit-timer SHALL count 0..CLKS_PER_BIT-1, clear on acceptance and on every state change, and each of START, each DATA bit, PARITY and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles.
REQ-017 tx SHALL be 0 in START, the current shift-register LSB in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-018 Data SHALL be sent LSB first; the shift register shifts right by one at each DATA bit boundary, and a 3-bit counter SHALL advance 0..7, leaving DATA after bit 7.
REQ-019 Parity bit SHALL be XOR of the 8 latched data bits, inverted when PARITY_ODD=1.
REQ-020 After DATA, the next state SHALL be PARITY if PARITY_EN=1, else STOP.
REQ-021 At the end of STOP the state SHALL return to IDLE, and done SHALL be 1 for exactly the first IDLE cycle.
REQ-022 Frame length from the cycle after acceptance to the last STOP cycle SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-023 A byte presented with tx_valid=1 in the done cycle SHALL be accepted at that edge, giving a minimum inter-frame gap of one idle-high cycle.
REQ-024 tx_valid held high while busy SHALL be accepted on the first IDLE cycle; no byte SHALL be lost or duplicated.

Reset
REQ-025 reset_n=0 SHALL immediately, without a clock edge, force state IDLE, tx=1, tx_ready=1, busy=0, done=0, and clear the bit-timer, bit counter and shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first byte after reset release SHALL be sent as a complete frame.

Verification (CLKS_PER_BIT=4)
REQ-027 Send 0xA5, no parity -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles); done pulses in cycle 41 after acceptance.
REQ-028 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 44 cycles; with PARITY_ODD=1 -> parity bit 0.
REQ-029 tx_valid held high with 0x55 then 0xAA -> two frames back to back with exactly one idle-high cycle between; tx_data changed mid-frame is not transmitted.
REQ-030 reset_n low during DATA bit 3 -> tx=1 and tx_ready=1 in the same cycle, no done; the next byte 0x3C sends a full correct frame.
REQ-031 tx_valid=0 for 100 cycles after reset -> tx=1, tx_ready=1, busy=0, done=0 throughout.
